// File: rtl/riscboy_ppu_vram_arb.sv
// Round-robin arbiter sharing one pipelined VRAM read port between PPU fetch agents.
// An in-order tag FIFO remembers who issued each address so returning beats are routed back.
module riscboy_ppu_vram_arb #(
  parameter int N_REQ         = 3,
  parameter int W_REQID       = 2,
  parameter int W_ADDR        = 18,
  parameter int W_DATA        = 16,
  parameter int MAX_IN_FLIGHT = 4,
  parameter int W_LEVEL       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_addr_vld,
  output logic [N_REQ-1:0]          req_addr_rdy,
  input  logic [N_REQ*W_ADDR-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_data_vld,
  output logic [W_DATA-1:0]         req_data,
  output logic                      bus_addr_vld,
  input  logic                      bus_addr_rdy,
  output logic [W_ADDR-1:0]         bus_addr,
  input  logic                      bus_data_vld,
  input  logic [W_DATA-1:0]         bus_data,
  output logic [W_LEVEL-1:0]        in_flight,
  output logic                      idle
);

  localparam int N_SLOT = 1 << W_REQID;
  localparam int W_PTR  = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;

  logic [W_REQID-1:0] rr_ptr_reg;
  logic               lock_reg;
  logic [W_REQID-1:0] lock_id_reg;
  logic [W_REQID-1:0] tag_mem [MAX_IN_FLIGHT];
  logic [W_PTR-1:0]   wr_ptr_reg;
  logic [W_PTR-1:0]   rd_ptr_reg;
  logic [W_LEVEL-1:0] level_reg;

  logic [N_SLOT-1:0]  vld_ext;
  logic [W_ADDR-1:0]  addr_arr [N_SLOT];
  logic [W_REQID-1:0] grant;
  logic [W_REQID-1:0] tag_head;
  logic               can_issue;
  logic               issue;
  logic               stall;
  logic               pop;

  // Pad requester vectors out to the full ID space so any grant value indexes safely
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
      if (gi < N_REQ) begin : g_used
        assign vld_ext[gi]  = req_addr_vld[gi];
        assign addr_arr[gi] = req_addr[gi*W_ADDR +: W_ADDR];
      end else begin : g_unused
        assign vld_ext[gi]  = 1'b0;
        assign addr_arr[gi] = '0;
      end
    end
  endgenerate

  function automatic logic [W_REQID-1:0] rr_pick(input logic [N_SLOT-1:0] vld,
                                                input logic [W_REQID-1:0] ptr);
    logic [W_REQID-1:0] pick;
    int                 idx;
    pick = ptr;
    // Walk furthest-first so the requester closest to ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (vld[W_REQID'(idx)]) pick = W_REQID'(idx);
    end
    return pick;
  endfunction

  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(MAX_IN_FLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign grant     = lock_reg ? lock_id_reg : rr_pick(vld_ext, rr_ptr_reg);
  assign can_issue = level_reg < W_LEVEL'(MAX_IN_FLIGHT);
  assign bus_addr_vld = can_issue && vld_ext[grant];
  assign bus_addr     = addr_arr[grant];
  assign issue    = bus_addr_vld && bus_addr_rdy;
  assign stall    = bus_addr_vld && !bus_addr_rdy;
  assign pop      = bus_data_vld && (level_reg != '0);
  assign tag_head = tag_mem[rd_ptr_reg];

  assign req_data  = bus_data;
  assign in_flight = level_reg;
  assign idle      = !(|req_addr_vld) && (level_reg == '0);

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_strobe
      assign req_addr_rdy[gi] = issue && (grant == W_REQID'(gi));
      assign req_data_vld[gi] = pop && (tag_head == W_REQID'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr_reg] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
    end else begin
      if (issue) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        rr_ptr_reg <= (grant == W_REQID'(N_REQ - 1)) ? '0 : grant + 1'b1;
        lock_reg   <= 1'b0;
      end else if (stall) begin
        // Freeze the choice so the address seen by a stalled bus cannot change
        lock_reg    <= 1'b1;
        lock_id_reg <= grant;
      end else begin
        lock_reg <= 1'b0;
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (issue && !pop)      level_reg <= level_reg + 1'b1;
      else if (pop && !issue) level_reg <= level_reg - 1'b1;
    end
  end

`ifdef FORMAL
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus_data_vld && level_reg == '0));
      assert (level_reg <= W_LEVEL'(MAX_IN_FLIGHT));
    end
  end
`endif

endmodule
